// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbitrating master and the memory slave.
// PADDR is fixed at 32 bits; requester word addresses are zero-extended onto it.
interface apb_master_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// and a per-transfer timeout that aborts ACCESS when PREADY never arrives.
//
// state    | meaning
// S_IDLE   | bus idle, requests sampled, winner latched onto the bus
// S_SETUP  | PSELx high, PENABLE low for exactly one cycle
// S_ACCESS | PSELx and PENABLE high, waiting for PREADY or timeout
module apb_master_arbiter #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              i_req0,
    input  logic              i_wr0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_wr1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_done0,
    output logic              o_done1,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    apb_master_arbiter_if.master apb
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state, w_state;
    logic              r_psel, w_psel;
    logic              r_penable, w_penable;
    logic              r_pwrite, w_pwrite;
    logic [ADDR_W-1:0] r_paddr, w_paddr;
    logic [DATA_W-1:0] r_pwdata, w_pwdata;
    logic              r_done0, w_done0;
    logic              r_done1, w_done1;
    logic              r_err, w_err;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_last_grant, w_last_grant;
    logic              w_winner;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state      <= S_IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_psel       <= w_psel;
            r_penable    <= w_penable;
            r_pwrite     <= w_pwrite;
            r_paddr      <= w_paddr;
            r_pwdata     <= w_pwdata;
            r_done0      <= w_done0;
            r_done1      <= w_done1;
            r_err        <= w_err;
            r_rdata      <= w_rdata;
            r_cnt        <= w_cnt;
            r_last_grant <= w_last_grant;
        end
    end

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        if (i_req0 && i_req1) w_winner = ~r_last_grant;
        else                  w_winner = i_req1;
    end

    always_comb begin
        w_state      = r_state;
        w_psel       = r_psel;
        w_penable    = r_penable;
        w_pwrite     = r_pwrite;
        w_paddr      = r_paddr;
        w_pwdata     = r_pwdata;
        w_done0      = 1'b0;
        w_done1      = 1'b0;
        w_err        = 1'b0;
        w_rdata      = r_rdata;
        w_cnt        = r_cnt;
        w_last_grant = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_pwrite     = w_winner ? i_wr1    : i_wr0;
                    w_paddr      = w_winner ? i_addr1  : i_addr0;
                    w_pwdata     = w_winner ? i_wdata1 : i_wdata0;
                    w_psel       = 1'b1;
                    w_penable    = 1'b0;
                    w_last_grant = w_winner;
                    w_state      = S_SETUP;
                end
            end
            S_SETUP: begin
                w_penable = 1'b1;
                w_cnt     = '0;
                w_state   = S_ACCESS;
            end
            S_ACCESS: begin
                // r_last_grant always names the owner of the transfer in flight.
                if (apb.PREADY) begin
                    w_done0   = ~r_last_grant;
                    w_done1   = r_last_grant;
                    if (!r_pwrite) w_rdata = apb.PRDATA;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_state   = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_done0   = ~r_last_grant;
                    w_done1   = r_last_grant;
                    w_err     = 1'b1;
                    w_rdata   = '0;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_state   = S_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_psel    = 1'b0;
                w_penable = 1'b0;
            end
        endcase
    end

    assign apb.PSELx   = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
    assign apb.PADDR   = {{(32 - ADDR_W){1'b0}}, r_paddr};
    assign apb.PWDATA  = r_pwdata;
    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Transaction-level bench: a word-memory slave with programmable wait states,
// checked against a reference of grant order, memory contents and returned data.
module tb_apb_master_arbiter;
    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0, wr0, req1, wr1;
    logic [2:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        o_done0, o_done1, o_err;
    logic [31:0] o_rdata;

    apb_master_arbiter_if #(.DATA_W(32)) apb();

    apb_master_arbiter #(.ADDR_W(3), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .i_req0  (req0),
        .i_wr0   (wr0),
        .i_addr0 (addr0),
        .i_wdata0(wdata0),
        .i_req1  (req1),
        .i_wr1   (wr1),
        .i_addr1 (addr1),
        .i_wdata1(wdata1),
        .o_done0 (o_done0),
        .o_done1 (o_done1),
        .o_err   (o_err),
        .o_rdata (o_rdata),
        .apb     (apb)
    );

    always #5 PCLK = ~PCLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] slave_mem [8];
    logic [31:0] ref_mem   [8];
    logic [31:0] ref_rdata;
    logic        ref_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_round(input logic r0, input logic r1, input logic w0, input logic w1,
                             input logic [2:0] a0, input logic [2:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1, input int wait_n);
        logic        win, ew, exp_err, got;
        logic [2:0]  ea;
        logic [31:0] ed;
        int          setup_cnt, acc_cnt, exp_acc;
        win       = (r0 && r1) ? ~ref_last : r1;
        ew        = win ? w1 : w0;
        ea        = win ? a1 : a0;
        ed        = win ? d1 : d0;
        exp_err   = (wait_n >= TIMEOUT);
        exp_acc   = exp_err ? TIMEOUT : wait_n + 1;
        setup_cnt = 0;
        acc_cnt   = 0;
        got       = 1'b0;
        if (!exp_err) begin
            if (ew) ref_mem[ea] = ed;
            else    ref_rdata   = ref_mem[ea];
        end else begin
            ref_rdata = '0;
        end
        ref_last = win;
        req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
        for (int c = 0; c < TIMEOUT + 8 && !got; c++) begin
            @(negedge PCLK);
            if (o_done0 || o_done1) begin
                got = 1'b1;
                check("done_who", {30'b0, o_done1, o_done0}, win ? 32'd2 : 32'd1);
                check("err", {31'b0, o_err}, {31'b0, exp_err});
                check("rdata", o_rdata, ref_rdata);
                check("idle_after", {30'b0, apb.PSELx, apb.PENABLE}, 32'd0);
                check("setup_cycles", setup_cnt, 32'd1);
                check("access_cycles", acc_cnt, exp_acc);
            end else if (apb.PSELx && !apb.PENABLE) begin
                setup_cnt++;
                if (setup_cnt == 1) begin
                    check("paddr", apb.PADDR, {29'b0, ea});
                    check("pwrite", {31'b0, apb.PWRITE}, {31'b0, ew});
                    if (ew) check("pwdata", apb.PWDATA, ed);
                    check("pulse_clr", {29'b0, o_done0, o_done1, o_err}, 32'd0);
                end
            end else if (apb.PSELx && apb.PENABLE) begin
                acc_cnt++;
            end
            if (apb.PSELx && apb.PENABLE && !got) begin
                apb.PREADY = (acc_cnt - 1 >= wait_n);
                apb.PRDATA = slave_mem[apb.PADDR[2:0]];
                if (apb.PREADY && apb.PWRITE) slave_mem[apb.PADDR[2:0]] = apb.PWDATA;
            end else begin
                apb.PREADY = 1'($urandom_range(0, 1));
                apb.PRDATA = $urandom;
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel_en"}, {30'b0, apb.PSELx, apb.PENABLE}, 32'd0);
        check({tag, "_done_err"}, {29'b0, o_done0, o_done1, o_err}, 32'd0);
        check({tag, "_rdata"}, o_rdata, 32'd0);
    endtask

    initial begin
        logic [1:0] pat;
        int         wt;
        PRESET = 1'b0;
        req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        apb.PREADY = 1'b0;
        apb.PRDATA = '0;
        for (int i = 0; i < 8; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        ref_rdata = '0;
        ref_last  = 1'b1;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESET = 1'b1;
        @(negedge PCLK);

        run_round(1, 0, 1, 0, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0, 1);
        run_round(0, 1, 0, 0, 3'd0, 3'd3, 32'h0, 32'h0, 1);
        check("readback", o_rdata, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++)
            run_round(1, 1, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                      $urandom, $urandom, 0);
        run_round(1, 0, 0, 0, 3'd5, 3'd0, 32'h0, 32'h0, TIMEOUT);
        run_round(0, 1, 0, 0, 3'd0, 3'd3, 32'h0, 32'h0, TIMEOUT - 1);
        run_round(0, 1, 1, 1, 3'd0, 3'd6, 32'h0, 32'h1234, TIMEOUT + 3);

        for (int r = 0; r < 60; r++) begin
            pat = 2'($urandom_range(1, 3));
            wt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 4))
                                              : int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
            run_round(pat[0], pat[1], 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                      $urandom, $urandom, wt);
        end

        // Abandon a transfer in ACCESS with an async reset.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd2;
        apb.PREADY = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("pre_reset_access", {30'b0, apb.PSELx, apb.PENABLE}, 32'd3);
        #2 PRESET = 1'b0;
        #1 check_reset_outputs("midreset");
        req0 = 1'b0;
        @(negedge PCLK);
        check_reset_outputs("held_reset");
        PRESET = 1'b1;
        ref_last  = 1'b1;
        ref_rdata = '0;
        run_round(1, 1, 0, 1, 3'd3, 3'd1, 32'h0, 32'hCAFEF00D, 0);
        run_round(1, 1, 0, 0, 3'd1, 3'd3, 32'h0, 32'h0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
